// File: rtl/reg_mm_arbiter_pkg.sv
// Shared types for the register-bus arbiter: FSM state encoding,
// the timeout fill pattern and the grant-index width helper.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

    // Read data returned when the slave never answers a read.
    localparam logic [31:0] REG_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Width of a master index; never narrower than one bit.
    function automatic int gnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_mm_arbiter_if.sv
// Avalon-MM bundle around the arbiter: per-master request side (m_*)
// and the single register-slave side (s_*).
//   slave  : the arbiter's view (takes m_* commands, drives s_* commands)
//   master : the environment's view (requesters plus the register block)
interface reg_mm_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32
);

    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [DATA_W-1:0]             m_readdata;
    logic [NUM_MASTERS-1:0]        m_readdatavalid;

    logic [ADDR_W-1:0]             s_address;
    logic                          s_read;
    logic                          s_write;
    logic [DATA_W-1:0]             s_writedata;
    logic                          s_waitrequest;
    logic [DATA_W-1:0]             s_readdata;
    logic                          s_readdatavalid;

    modport slave (
        input  m_address, m_read, m_write, m_writedata,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output s_address, s_read, s_write, s_writedata,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport master (
        output m_address, m_read, m_write, m_writedata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  s_address, s_read, s_write, s_writedata,
        output s_waitrequest, s_readdata, s_readdatavalid
    );

endinterface

// File: rtl/reg_mm_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request bit at or after ptr, wrapping.
// Ports: req (requests), ptr (start index) -> valid, idx (chosen master).
module rr_priority_picker #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [W:0]     sum;

    // Rotating the doubled vector puts req[ptr] at bit 0, so the
    // lowest set bit of the low half is the next owner in order.
    assign dbl = {req, req} >> ptr;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (W + 1)'(k);
                if (sum >= (W + 1)'(N)) begin
                    sum = sum - (W + 1)'(N);
                end
                idx = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM register slave among
// NUM_MASTERS requesters, one transaction in flight at a time.
// Ports: clk, rst (sync, active-high), bus (slave modport: m_* from
// masters, s_* to the register block), busy, grant_id, and
// timeout_err when REG_ARB_TIMEOUT_EN is defined (read timeout).
module reg_mm_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    reg_mm_arbiter_if.slave                bus,
    output logic                           busy,
    output logic [gnt_w(NUM_MASTERS)-1:0]  grant_id
`ifdef REG_ARB_TIMEOUT_EN
    ,
    output logic                           timeout_err
`endif
);

    localparam int GW = gnt_w(NUM_MASTERS);

    arb_state_e state_q, state_d;

    logic [GW-1:0]          gnt_q, gnt_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic [NUM_MASTERS-1:0] req;
    logic                   pick_valid;
    logic [GW-1:0]          pick_idx;

    logic                   sel_rd, sel_wr;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wd;

    logic                   s_rd, s_wr;
    logic [ADDR_W-1:0]      s_addr;
    logic [DATA_W-1:0]      s_wd;
    logic [NUM_MASTERS-1:0] mwait;

    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [NUM_MASTERS-1:0] rdv_q, rdv_d;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif

    assign req = bus.m_read | bus.m_write;

    rr_priority_picker #(
        .N (NUM_MASTERS),
        .W (GW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        gnt_oh   = '0;
        sel_rd   = 1'b0;
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_wd   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_q == GW'(i)) begin
                gnt_oh[i] = 1'b1;
                sel_rd    = bus.m_read[i];
                sel_wr    = bus.m_write[i];
                sel_addr  = bus.m_address[i*ADDR_W +: ADDR_W];
                sel_wd    = bus.m_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        s_rd    = 1'b0;
        s_wr    = 1'b0;
        s_addr  = '0;
        s_wd    = '0;
        mwait   = '1;
        rdata_d = rdata_q;
        rdv_d   = '0;
`ifdef REG_ARB_TIMEOUT_EN
        tcnt_d  = '0;
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    state_d = CMD;
                end
            end
            CMD: begin
                // Write wins when a master raises both strobes.
                s_wr   = sel_wr;
                s_rd   = sel_rd & ~sel_wr;
                s_addr = sel_addr;
                s_wd   = sel_wd;
                // A master that dropped its command cannot be
                // accepted; the arbiter simply keeps waiting.
                if ((sel_rd | sel_wr) && !bus.s_waitrequest) begin
                    mwait   = ~gnt_oh;
                    ptr_d   = (gnt_q == GW'(NUM_MASTERS - 1)) ?
                              '0 : gnt_q + GW'(1);
                    state_d = sel_wr ? IDLE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.s_readdatavalid) begin
                    rdata_d = bus.s_readdata;
                    rdv_d   = gnt_oh;
                    state_d = IDLE;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    rdata_d = DATA_W'(REG_ARB_TIMEOUT_DATA);
                    rdv_d   = gnt_oh;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
            rdv_q   <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            tcnt_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
`ifdef REG_ARB_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.s_read          = s_rd;
    assign bus.s_write         = s_wr;
    assign bus.s_address       = s_addr;
    assign bus.s_writedata     = s_wd;
    assign bus.m_waitrequest   = mwait;
    assign bus.m_readdata      = rdata_q;
    assign bus.m_readdatavalid = rdv_q;
    assign busy                = (state_q != IDLE);
    assign grant_id            = gnt_q;
`ifdef REG_ARB_TIMEOUT_EN
    assign timeout_err         = tmo_q;
`endif

endmodule
